// File: rtl/pwr_seq_pkg.sv
// Shared types, defaults and helpers for the PD_GATED power-sequencing controller.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    S_ON      = 3'd0,
    S_ISO     = 3'd1,
    S_SAVE    = 3'd2,
    S_PWR_DN  = 3'd3,
    S_OFF     = 3'd4,
    S_PWR_UP  = 3'd5,
    S_RESTORE = 3'd6,
    S_UNISO   = 3'd7
  } pwr_state_e;

  localparam int DEF_ISO_DLY      = 2;
  localparam int DEF_SAVE_CYC     = 1;
  localparam int DEF_RAMP_TIMEOUT = 8;

  typedef struct packed {
    logic iso_enable;
    logic pwr_en;
    logic save;
    logic restore;
    logic dom_rst_n;
    logic ready;
  } pwr_out_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Isolation stays on everywhere the domain is unpowered or held in reset.
  function automatic pwr_out_t decode_outputs(input pwr_state_e s);
    pwr_out_t o;
    o = '0;
    case (s)
      S_ON:      begin o.pwr_en = 1'b1; o.dom_rst_n = 1'b1; o.ready = 1'b1; end
      S_ISO:     begin o.iso_enable = 1'b1; o.pwr_en = 1'b1; o.dom_rst_n = 1'b1; end
      S_SAVE:    begin o.iso_enable = 1'b1; o.pwr_en = 1'b1; o.dom_rst_n = 1'b1; o.save = 1'b1; end
      S_PWR_DN:  begin o.iso_enable = 1'b1; end
      S_OFF:     begin o.iso_enable = 1'b1; end
      S_PWR_UP:  begin o.iso_enable = 1'b1; o.pwr_en = 1'b1; end
      S_RESTORE: begin o.iso_enable = 1'b1; o.pwr_en = 1'b1; o.dom_rst_n = 1'b1; o.restore = 1'b1; end
      S_UNISO:   begin o.iso_enable = 1'b1; o.pwr_en = 1'b1; o.dom_rst_n = 1'b1; end
      default:   begin o.pwr_en = 1'b1; o.dom_rst_n = 1'b1; o.ready = 1'b1; end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable down-counter shared by the isolation, retention and ramp waits.
module pwr_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Holds at zero once expired so a stalled state keeps seeing expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-down/power-up sequencer for PD_GATED: isolation, retention, switch and domain reset.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int ISO_DLY      = DEF_ISO_DLY,
  parameter int SAVE_CYC     = DEF_SAVE_CYC,
  parameter int RAMP_TIMEOUT = DEF_RAMP_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       pwr_ack,
  input  logic       err_clr,
  output logic       iso_enable,
  output logic       pwr_en,
  output logic       save,
  output logic       restore,
  output logic       dom_rst_n,
  output logic [2:0] state,
  output logic       ready,
  output logic       err
);

  localparam int CW = cnt_width(ISO_DLY, SAVE_CYC, RAMP_TIMEOUT);
  // The timer is loaded with N-1 so that a state lasts exactly N cycles.
  localparam logic [CW-1:0] ISO_LOAD  = CW'(ISO_DLY - 1);
  localparam logic [CW-1:0] SAVE_LOAD = CW'(SAVE_CYC - 1);
  localparam logic [CW-1:0] RAMP_LOAD = CW'(RAMP_TIMEOUT - 1);

  pwr_state_e      cur_state;
  pwr_state_e      next_state;
  pwr_out_t        outs;
  logic            timeout;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            expired;

  pwr_seq_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_comb begin
    next_state = cur_state;
    timeout    = 1'b0;
    case (cur_state)
      S_ON:      if (sleep_req) next_state = S_ISO;
      S_ISO:     if (expired) next_state = S_SAVE;
      S_SAVE:    if (expired) next_state = S_PWR_DN;
      S_PWR_DN: begin
        if (!pwr_ack) begin
          next_state = S_OFF;
        end else if (expired) begin
          next_state = S_OFF;
          timeout    = 1'b1;
        end
      end
      S_OFF:     if (wake_req) next_state = S_PWR_UP;
      S_PWR_UP: begin
        if (pwr_ack) begin
          next_state = S_RESTORE;
        end else if (expired) begin
          next_state = S_OFF;
          timeout    = 1'b1;
        end
      end
      S_RESTORE: if (expired) next_state = S_UNISO;
      S_UNISO:   if (expired) next_state = S_ON;
      default:   next_state = S_ON;
    endcase
  end

  always_comb begin
    load     = (next_state != cur_state);
    load_val = '0;
    case (next_state)
      S_ISO, S_UNISO:     load_val = ISO_LOAD;
      S_SAVE, S_RESTORE:  load_val = SAVE_LOAD;
      S_PWR_DN, S_PWR_UP: load_val = RAMP_LOAD;
      default:            load_val = '0;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_ON;
      outs      <= decode_outputs(S_ON);
      err       <= 1'b0;
    end else begin
      cur_state <= next_state;
      outs      <= decode_outputs(next_state);
      if (timeout) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  assign iso_enable = outs.iso_enable;
  assign pwr_en     = outs.pwr_en;
  assign save       = outs.save;
  assign restore    = outs.restore;
  assign dom_rst_n  = outs.dom_rst_n;
  assign ready      = outs.ready;
  assign state      = cur_state;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Bench for pwr_seq_ctrl: directed sequences plus random traffic against a cycle-count model.
module tb_pwr_seq_ctrl;

  localparam int ISO_DLY      = 2;
  localparam int SAVE_CYC     = 1;
  localparam int RAMP_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sleep_req = 1'b0;
  logic       wake_req = 1'b0;
  logic       pwr_ack = 1'b1;
  logic       err_clr = 1'b0;
  logic       iso_enable, pwr_en, save, restore, dom_rst_n, ready, err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int m_state = 0;
  int m_cnt   = 1;
  bit m_err   = 1'b0;

  pwr_seq_ctrl #(
    .ISO_DLY      (ISO_DLY),
    .SAVE_CYC     (SAVE_CYC),
    .RAMP_TIMEOUT (RAMP_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sleep_req  (sleep_req),
    .wake_req   (wake_req),
    .pwr_ack    (pwr_ack),
    .err_clr    (err_clr),
    .iso_enable (iso_enable),
    .pwr_en     (pwr_en),
    .save       (save),
    .restore    (restore),
    .dom_rst_n  (dom_rst_n),
    .state      (state),
    .ready      (ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Expected {iso_enable, pwr_en, save, restore, dom_rst_n, ready} per state number.
  function automatic logic [5:0] exp_outs(input int s);
    case (s)
      0: return 6'b010011;
      1: return 6'b110010;
      2: return 6'b111010;
      3: return 6'b100000;
      4: return 6'b100000;
      5: return 6'b110000;
      6: return 6'b110110;
      7: return 6'b110010;
      default: return 6'b000000;
    endcase
  endfunction

  // Reference model: state number plus the number of cycles spent in it so far.
  always @(posedge clk) begin
    int ns;
    bit to;
    if (rst) begin
      m_state <= 0;
      m_cnt   <= 1;
      m_err   <= 1'b0;
    end else begin
      ns = m_state;
      to = 1'b0;
      case (m_state)
        0: if (sleep_req) ns = 1;
        1: if (m_cnt >= ISO_DLY) ns = 2;
        2: if (m_cnt >= SAVE_CYC) ns = 3;
        3: if (!pwr_ack) ns = 4; else if (m_cnt >= RAMP_TIMEOUT) begin ns = 4; to = 1'b1; end
        4: if (wake_req) ns = 5;
        5: if (pwr_ack) ns = 6; else if (m_cnt >= RAMP_TIMEOUT) begin ns = 4; to = 1'b1; end
        6: if (m_cnt >= SAVE_CYC) ns = 7;
        7: if (m_cnt >= ISO_DLY) ns = 0;
        default: ns = 0;
      endcase
      m_err   <= to ? 1'b1 : (err_clr ? 1'b0 : m_err);
      m_cnt   <= (ns != m_state) ? 1 : m_cnt + 1;
      m_state <= ns;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic a, input logic c);
    sleep_req = s;
    wake_req  = w;
    pwr_ack   = a;
    err_clr   = c;
  endtask

  task automatic waitState(input int target, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state == 3'(target)) break;
    end
    checkOutput(name, state, target);
  endtask

  // Every cycle: outputs against the model, plus the safety invariants.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_state", state, m_state);
      checkOutput("model_outs", {iso_enable, pwr_en, save, restore, dom_rst_n, ready}, exp_outs(m_state));
      checkOutput("model_err", err, m_err);
      if (!pwr_en || !dom_rst_n) checkOutput("iso_invariant", iso_enable, 1);
      if (save) checkOutput("save_needs_power", pwr_en, 1);
      checkOutput("save_restore_excl", save & restore, 0);
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_pwr_en", pwr_en, 1);
    checkOutput("rst_dom_rst_n", dom_rst_n, 1);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_iso", iso_enable, 0);
    checkOutput("rst_save", save, 0);
    checkOutput("rst_restore", restore, 0);
    checkOutput("rst_err", err, 0);
    rst = 1'b0;

    // Full sleep with pwr_ack dropping one cycle after pwr_en falls
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("sleep_iso_now", iso_enable, 1);
    checkOutput("sleep_ready_low", ready, 0);
    checkOutput("sleep_state_iso", state, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("iso_second_cycle", state, 1);
    @(negedge clk);
    checkOutput("save_state", state, 2);
    checkOutput("save_pulse", save, 1);
    @(negedge clk);
    checkOutput("pwr_dn_state", state, 3);
    checkOutput("pwr_dn_pwr_en", pwr_en, 0);
    checkOutput("save_one_cycle", save, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("off_state", state, 4);
    checkOutput("off_err", err, 0);

    // Full wake with pwr_ack rising after 3 cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("pwr_up_state", state, 5);
    checkOutput("pwr_up_pwr_en", pwr_en, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("restore_state", state, 6);
    checkOutput("restore_pulse", restore, 1);
    @(negedge clk);
    checkOutput("uniso_state", state, 7);
    checkOutput("restore_one_cycle", restore, 0);
    checkOutput("uniso_iso1", iso_enable, 1);
    @(negedge clk);
    checkOutput("uniso_iso2", iso_enable, 1);
    @(negedge clk);
    checkOutput("wake_iso_low", iso_enable, 0);
    checkOutput("wake_ready", ready, 1);
    checkOutput("wake_state_on", state, 0);

    // Ramp timeout in PWR_UP, then err_clr
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitState(3, "reach_pwr_dn");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4, "reach_off");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("to_pwr_up", state, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= RAMP_TIMEOUT; i++) begin
      @(negedge clk);
      checkOutput("up_waiting", state, 5);
    end
    @(negedge clk);
    checkOutput("up_timeout_state", state, 4);
    checkOutput("up_timeout_err", err, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("err_cleared", err, 0);

    // Both requests in OFF: wake wins; sleep during UNISO is dropped
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("off_conflict", state, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitState(7, "reach_uniso");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("uniso_hold", state, 7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("uniso_to_on", state, 0);
    @(negedge clk);
    checkOutput("sleep_not_queued", state, 0);

    // Both requests in ON: sleep wins; then reset from SAVE
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("on_conflict", state, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitState(2, "reach_save");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_state", state, 0);
    checkOutput("midrst_iso", iso_enable, 0);
    rst = 1'b0;

    // PWR_DN timeout with err_clr held: timeout wins
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitState(3, "reach_pwr_dn2");
    for (int i = 2; i <= RAMP_TIMEOUT; i++) begin
      @(negedge clk);
      checkOutput("dn_waiting", state, 3);
    end
    @(negedge clk);
    checkOutput("dn_timeout_state", state, 4);
    checkOutput("dn_timeout_err_wins", err, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic; pwr_ack loosely tracks pwr_en with random lag and glitches
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      sleep_req = ($urandom_range(0, 9) < 2);
      wake_req  = ($urandom_range(0, 9) < 2);
      err_clr   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) pwr_ack = pwr_en;
      else if ($urandom_range(0, 19) == 0) pwr_ack = ~pwr_ack;
    end
    rst = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
